// File: rtl/sd_pkg.sv
// Shared types and defaults for the sigma-delta modulator slice.
package sd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int OSR_DEF    = 128;

  // Midscale code 2^(w-1): the zero point of an unsigned w-bit sample.
  function automatic int midscale(input int w);
    return 32'sd1 <<< (w - 32'sd1);
  endfunction

endpackage

// File: rtl/sd_loop.sv
// Modulator arithmetic core: first-order accumulator by default,
// second-order saturating loop when SDM_SECOND_ORDER_EN is defined.
module sd_loop
  import sd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [DATA_W-1:0] active,
  output logic              bit_s
);

`ifdef SDM_SECOND_ORDER_EN
  localparam int I1_W  = DATA_W + 2;
  localparam int I2_W  = DATA_W + 4;
  localparam int EXT_W = DATA_W + 6;
  localparam logic signed [EXT_W-1:0] MID_X  = EXT_W'(midscale(DATA_W));
  localparam logic signed [EXT_W-1:0] I1_MAX = EXT_W'((32'sd1 <<< (I1_W - 1)) - 32'sd1);
  localparam logic signed [EXT_W-1:0] I1_MIN = -I1_MAX - EXT_W'(32'sd1);
  localparam logic signed [EXT_W-1:0] I2_MAX = EXT_W'((32'sd1 <<< (I2_W - 1)) - 32'sd1);
  localparam logic signed [EXT_W-1:0] I2_MIN = -I2_MAX - EXT_W'(32'sd1);

  logic signed [I1_W-1:0]  i1_r, i1_eff_s, i1_nxt_s;
  logic signed [I2_W-1:0]  i2_r, i2_eff_s, i2_nxt_s;
  logic signed [EXT_W-1:0] u_s, f_s, s1_s, s2_s;
  logic                    fb_r;

  // Integrator update with saturation; the first RUN step starts from zero state.
  always_comb begin
    i1_eff_s = clr ? {I1_W{1'b0}} : i1_r;
    i2_eff_s = clr ? {I2_W{1'b0}} : i2_r;
    u_s  = $signed({{(EXT_W-DATA_W){1'b0}}, active}) - MID_X;
    f_s  = fb_r ? MID_X : -MID_X;
    s1_s = $signed({{(EXT_W-I1_W){i1_eff_s[I1_W-1]}}, i1_eff_s}) + u_s - f_s;
    if (s1_s > I1_MAX) begin
      i1_nxt_s = I1_MAX[I1_W-1:0];
    end else if (s1_s < I1_MIN) begin
      i1_nxt_s = I1_MIN[I1_W-1:0];
    end else begin
      i1_nxt_s = s1_s[I1_W-1:0];
    end
    s2_s = $signed({{(EXT_W-I2_W){i2_eff_s[I2_W-1]}}, i2_eff_s})
         + $signed({{(EXT_W-I1_W){i1_nxt_s[I1_W-1]}}, i1_nxt_s}) - f_s;
    if (s2_s > I2_MAX) begin
      i2_nxt_s = I2_MAX[I2_W-1:0];
    end else if (s2_s < I2_MIN) begin
      i2_nxt_s = I2_MIN[I2_W-1:0];
    end else begin
      i2_nxt_s = s2_s[I2_W-1:0];
    end
    bit_s = !i2_nxt_s[I2_W-1];
  end

  // Integrator and feedback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_r <= {I1_W{1'b0}};
      i2_r <= {I2_W{1'b0}};
      fb_r <= 1'b0;
    end else if (step) begin
      i1_r <= i1_nxt_s;
      i2_r <= i2_nxt_s;
      fb_r <= bit_s;
    end else if (clr) begin
      i1_r <= {I1_W{1'b0}};
      i2_r <= {I2_W{1'b0}};
      fb_r <= 1'b0;
    end else begin
      i1_r <= i1_r;
      i2_r <= i2_r;
      fb_r <= fb_r;
    end
  end
`else
  logic [DATA_W-1:0] acc_r, acc_eff_s;
  logic [DATA_W:0]   sum_s;

  // The carry out of acc + active is the output bit.
  always_comb begin
    acc_eff_s = clr ? {DATA_W{1'b0}} : acc_r;
    sum_s     = {1'b0, acc_eff_s} + {1'b0, active};
    bit_s     = sum_s[DATA_W];
  end

  // Accumulator; kept across RUN frames so density is exact over 2^DATA_W clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {DATA_W{1'b0}};
    end else if (step) begin
      acc_r <= sum_s[DATA_W-1:0];
    end else if (clr) begin
      acc_r <= {DATA_W{1'b0}};
    end else begin
      acc_r <= acc_r;
    end
  end
`endif

endmodule

// File: rtl/sd_modulator.sv
// Sigma-delta modulator top: frame counter, IDLE/RUN FSM, sample handshake.
// Define SDM_SECOND_ORDER_EN to build the second-order loop.
module sd_modulator
  import sd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OSR    = OSR_DEF,
  parameter int CNT_W  = $clog2(OSR)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_W-1:0] SAMPLE_IN,
  input  logic              SAMPLE_VALID,
  output logic              SAMPLE_READY,
  output logic              BIT_OUT,
  output logic              FRAME_START,
  output logic              UNDERRUN
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] hold_r, active_r, active_nxt_s;
  logic              hold_full_r, hold_full_nxt_s, hold_take_s;
  logic              ready_r, bit_r, frame_start_r, underrun_r;
  logic              frame_start_nxt_s, underrun_nxt_s;
  logic              boundary_s, xfer_s, run_nxt_s, clr_s, loop_bit_s;

  assign boundary_s = (cnt_r == CNT_LAST);
  assign xfer_s     = SAMPLE_VALID && ready_r;
  assign run_nxt_s  = (state_nxt_s == RUN);
  assign clr_s      = (state_r == IDLE);

  // Boundary decisions: next state, sample promotion and per-frame pulses.
  always_comb begin
    state_nxt_s       = state_r;
    hold_take_s       = 1'b0;
    frame_start_nxt_s = 1'b0;
    underrun_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (boundary_s && EN && hold_full_r) begin
          state_nxt_s       = RUN;
          hold_take_s       = 1'b1;
          frame_start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (boundary_s && !EN) begin
          state_nxt_s = IDLE;
        end else if (boundary_s) begin
          frame_start_nxt_s = 1'b1;
          hold_take_s       = hold_full_r;
          underrun_nxt_s    = !hold_full_r;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    if (hold_take_s) begin
      active_nxt_s = hold_r;
    end else begin
      active_nxt_s = active_r;
    end
    // A transfer only happens into an empty hold, so it never meets a take.
    if (xfer_s) begin
      hold_full_nxt_s = 1'b1;
    end else if (hold_take_s) begin
      hold_full_nxt_s = 1'b0;
    end else begin
      hold_full_nxt_s = hold_full_r;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame counter, sample registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r         <= {CNT_W{1'b0}};
      hold_r        <= {DATA_W{1'b0}};
      hold_full_r   <= 1'b0;
      active_r      <= {DATA_W{1'b0}};
      ready_r       <= 1'b0;
      bit_r         <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      cnt_r         <= cnt_r + CNT_W'(1'b1);
      hold_r        <= xfer_s ? SAMPLE_IN : hold_r;
      hold_full_r   <= hold_full_nxt_s;
      active_r      <= active_nxt_s;
      ready_r       <= !hold_full_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      underrun_r    <= underrun_nxt_s;
      // IDLE emits a midscale 0,1,0,1 pattern.
      bit_r         <= run_nxt_s ? loop_bit_s : !bit_r;
    end
  end

  sd_loop #(
    .DATA_W(DATA_W)
  ) u_loop (
    .clk   (CLK),
    .rst   (RST),
    .clr   (clr_s),
    .step  (run_nxt_s),
    .active(active_nxt_s),
    .bit_s (loop_bit_s)
  );

  assign SAMPLE_READY = ready_r;
  assign BIT_OUT      = bit_r;
  assign FRAME_START  = frame_start_r;
  assign UNDERRUN     = underrun_r;

endmodule

// File: tb/tb_sd_modulator.sv
// Self-checking bench for sd_modulator: cycle-accurate reference model
// (bitstream from cumulative-sum arithmetic) plus directed frame checks.
module tb_sd_modulator;

  localparam int DATA_W = 8;
  localparam int OSR    = 128;

  logic              CLK = 1'b0;
  logic              RST, EN, SAMPLE_VALID;
  logic [DATA_W-1:0] SAMPLE_IN;
  logic              SAMPLE_READY, BIT_OUT, FRAME_START, UNDERRUN;

  int errors = 0;
  int checks = 0;

  // reference model state
  int     m_pos, m_hold, m_active;
  bit     m_run, m_hold_full, m_ready, m_bit, m_fs, m_ur;
  longint m_sum;

  // stimulus / observation helpers
  bit   last_xfer, g_rand;
  logic [7:0] g_fixed;
  int   ones, urs, fss;

  always #5 CLK = ~CLK;

  sd_modulator #(.DATA_W(DATA_W), .OSR(OSR)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .SAMPLE_IN   (SAMPLE_IN),
    .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY),
    .BIT_OUT     (BIT_OUT),
    .FRAME_START (FRAME_START),
    .UNDERRUN    (UNDERRUN)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One clock: advance the model by the spec rules, then compare every output.
  task automatic tick();
    bit         xfer, bnd, en, rst;
    logic [7:0] smp;
    longint     prev;
    rst  = RST;
    en   = EN;
    smp  = SAMPLE_IN;
    xfer = SAMPLE_VALID && m_ready && !rst;
    bnd  = (m_pos == OSR - 1);
    @(posedge CLK);
    #1;
    last_xfer = xfer;
    if (rst) begin
      m_pos = 0; m_run = 0; m_hold_full = 0; m_ready = 0;
      m_bit = 0; m_fs = 0; m_ur = 0; m_active = 0; m_sum = 0;
    end else begin
      m_fs = 0;
      m_ur = 0;
      if (bnd) begin
        if (!m_run) begin
          if (en && m_hold_full) begin
            m_run = 1; m_active = m_hold; m_hold_full = 0; m_sum = 0; m_fs = 1;
          end
        end else if (!en) begin
          m_run = 0;
        end else begin
          m_fs = 1;
          if (m_hold_full) begin
            m_active = m_hold; m_hold_full = 0;
          end else begin
            m_ur = 1;
          end
        end
      end
      if (xfer) begin
        m_hold = int'(smp); m_hold_full = 1;
      end
      if (m_run) begin
        prev  = m_sum;
        m_sum = m_sum + m_active;
        m_bit = ((m_sum / 256) != (prev / 256));
      end else begin
        m_bit = !m_bit;
      end
      m_ready = !m_hold_full;
      m_pos   = (m_pos + 1) % OSR;
    end
    if (BIT_OUT === 1'b1) ones++;
    if (UNDERRUN === 1'b1) urs++;
    if (FRAME_START === 1'b1) fss++;
    check_bit("bit_out", BIT_OUT, m_bit);
    check_bit("sample_ready", SAMPLE_READY, m_ready);
    check_bit("frame_start", FRAME_START, m_fs);
    check_bit("underrun", UNDERRUN, m_ur);
  endtask

  task automatic feed();
    if (last_xfer) SAMPLE_IN = g_rand ? 8'($urandom_range(0, 255)) : g_fixed;
  endtask

  task automatic tick_feed();
    tick();
    feed();
  endtask

  task automatic to_last();
    for (int i = 0; i < 2 * OSR && m_pos != OSR - 1; i++) tick_feed();
  endtask

  // One full frame (observed positions 0..OSR-1), optional ones-count check.
  task automatic frame(input int n_exp, input string tag);
    ones = 0; urs = 0; fss = 0;
    for (int i = 0; i < OSR; i++) tick_feed();
    if (n_exp >= 0) check_int(tag, ones, n_exp);
  endtask

  initial begin
    int o1, x, found;
    RST = 1'b1; EN = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE_IN = 8'h00;
    g_fixed = 8'h00; g_rand = 1'b0; last_xfer = 1'b0;
    m_pos = 0; m_hold = 0; m_active = 0; m_sum = 0;
    m_run = 0; m_hold_full = 0; m_ready = 0; m_bit = 0; m_fs = 0; m_ur = 0;

    // reset: outputs all zero, ready rises on the first clock after release
    tick(); tick();
    check_bit("reset_ready", SAMPLE_READY, 1'b0);
    check_bit("reset_bit", BIT_OUT, 1'b0);
    RST = 1'b0;
    tick();
    check_bit("ready_after_reset", SAMPLE_READY, 1'b1);
    check_bit("idle_first_toggle", BIT_OUT, 1'b1);
    for (int i = 0; i < 6; i++) tick();

    // zero sample
    EN = 1'b1; SAMPLE_VALID = 1'b1; g_fixed = 8'h00; SAMPLE_IN = 8'h00;
    to_last();
    frame(0, "zero_frame");
    check_int("zero_frame_start", fss, 1);

    // midscale
    g_fixed = 8'h80; SAMPLE_IN = 8'h80;
    frame(0, "zero_frame_2");
    frame(64, "mid_frame_1");
    check_int("mid_no_underrun", urs, 0);
    frame(64, "mid_frame_2");

    // full scale over two frames
    g_fixed = 8'hFF; SAMPLE_IN = 8'hFF;
    frame(64, "mid_frame_3");
    frame(-1, "");
    o1 = ones;
    frame(-1, "");
    check_int("full_scale_256", o1 + ones, 255);

    // random samples: floor/ceil of x*OSR/256 ones per frame
    g_rand = 1'b1;
    frame(-1, "");
    for (int k = 0; k < 4; k++) begin
      frame(-1, "");
      x = m_active;
      check_int("rand_density", int'(ones >= x / 2 && ones <= (x + 1) / 2), 1);
    end

    // underrun with a transfer landing on the boundary cycle
    g_rand = 1'b0; g_fixed = 8'hC8; SAMPLE_IN = 8'hC8;
    frame(-1, "");
    SAMPLE_VALID = 1'b0;
    frame(100, "c8_frame");
    SAMPLE_VALID = 1'b1; SAMPLE_IN = 8'h30; g_fixed = 8'h30;
    ones = 0; urs = 0; fss = 0;
    tick_feed();
    check_bit("underrun_pulse", UNDERRUN, 1'b1);
    for (int i = 0; i < OSR - 1; i++) tick_feed();
    check_int("underrun_repeat", ones, 100);
    check_int("underrun_count", urs, 1);
    frame(24, "collision_sample");

    // EN drop mid-frame: frame completes, then IDLE toggling
    ones = 0;
    for (int i = 0; i < 60; i++) tick_feed();
    EN = 1'b0;
    for (int i = 0; i < OSR - 60; i++) tick_feed();
    check_int("en_drop_completes", ones, 24);
    frame(64, "idle_toggle");
    check_int("idle_no_frame_start", fss, 0);

    // reset at cnt=50 in RUN, then the counter grid restarts from 0
    EN = 1'b1;
    for (int i = 0; i < 51; i++) tick_feed();
    RST = 1'b1;
    tick();
    check_bit("midrun_reset_ready", SAMPLE_READY, 1'b0);
    check_bit("midrun_reset_bit", BIT_OUT, 1'b0);
    RST = 1'b0;
    found = -1;
    for (int i = 1; i <= 3 * OSR && found < 0; i++) begin
      tick_feed();
      if (FRAME_START === 1'b1) found = i;
    end
    check_int("restart_frame_start_delay", found, OSR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
